keypad_scan: RTL and testbench

- Scans a 4x3 active-low matrix keypad, debounces it and presents the pressed digit as a one-hot 10-bit level.
- It is the producer for the countdown timer's `keypad[9:0]` input, so a released-then-pressed digit is seen as a 0→nonzero edge.
- It also reports `*` and `#` levels, a 4-bit key code and a single-cycle press strobe. It runs on the 1 kHz system clock.

---
 rtl/keypad_scan_if.sv | 20 ++
 rtl/keypad_scan.sv | 165 ++++++++++++++++
 tb/tb_keypad_scan.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - keypad matrix pins and decoded key outputs
interface keypad_scan_if;
   logic [2:0] key_col;
   logic [3:0] key_row;
   logic [9:0] keypad;
   logic       key_star;
   logic       key_hash;
   logic [3:0] key_code;
   logic       key_pulse;

   modport master (
      input  key_col,
      output key_row, keypad, key_star, key_hash, key_code, key_pulse
   );

   modport slave (
      output key_col,
      input  key_row, keypad, key_star, key_hash, key_code, key_pulse
   );
endinterface

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x3 matrix keypad scanner with debounce and one-hot digit output
module keypad_scan #(
   parameter int ROW_CYC  = 4,
   parameter int DB_SCANS = 3
) (
   input  logic          clk,
   input  logic          rst,
   keypad_scan_if.master kp
);
   localparam int SW = (ROW_CYC > 1) ? $clog2(ROW_CYC) : 1;
   localparam int CW = (DB_SCANS > 1) ? $clog2(DB_SCANS) : 1;
   localparam logic [SW-1:0] SLOT_LAST  = SW'(ROW_CYC - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(DB_SCANS - 1);
   localparam logic [3:0]    CODE_MULTI = 4'd14;
   localparam logic [3:0]    CODE_NONE  = 4'd15;

   typedef enum logic [1:0] {S_NONE, S_KEY, S_GAP} out_state_t;

   logic [2:0]    col_s1, col_s2;
   logic [SW-1:0] slot;
   logic [1:0]    row_idx;
   logic [3:0]    row_drv;
   logic [1:0]    acc_n;
   logic [3:0]    acc_code;
   logic [3:0]    cand;
   logic [CW-1:0] db_cnt;

   out_state_t state, state_n;
   logic [3:0] stable, stable_n;
   logic [3:0] code_q, code_n;
   logic       pulse_q, pulse_n;

   logic       sample, scan_end, accept;
   logic [2:0] row_n, tot_n;
   logic [3:0] row_code, tot_code, scan_res;

   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      if (r == 2'd3)
         return (c == 2'd0) ? 4'd10 : ((c == 2'd1) ? 4'd0 : 4'd11);
      return ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
   endfunction

   // Low columns are counted across the whole scan; acc_code is only meaningful when acc_n == 1.
   always_comb begin
      sample   = (slot == SLOT_LAST);
      scan_end = sample && (row_idx == 2'd3);
      row_n    = 3'd0;
      row_code = CODE_NONE;
      for (int c = 0; c < 3; c++) begin
         if (!col_s2[c]) begin
            row_n    = row_n + 3'd1;
            row_code = key_map(row_idx, 2'(c));
         end
      end
      tot_n    = {1'b0, acc_n} + row_n;
      tot_code = (acc_n != 2'd0) ? acc_code : row_code;
      if (tot_n == 3'd0)
         scan_res = CODE_NONE;
      else if (tot_n == 3'd1)
         scan_res = tot_code;
      else
         scan_res = CODE_MULTI;
      accept = scan_end && ((DB_SCANS == 1) || ((scan_res == cand) && (db_cnt >= CNT_LAST)));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_s1   <= 3'b111;
         col_s2   <= 3'b111;
         slot     <= '0;
         row_idx  <= 2'd0;
         row_drv  <= 4'b1110;
         acc_n    <= 2'd0;
         acc_code <= CODE_NONE;
         cand     <= CODE_NONE;
         db_cnt   <= '0;
      end else begin
         col_s1 <= kp.key_col;
         col_s2 <= col_s1;
         if (sample) begin
            slot    <= '0;
            row_idx <= row_idx + 2'd1;
            row_drv <= ~(4'b0001 << (row_idx + 2'd1));
            if (scan_end) begin
               acc_n    <= 2'd0;
               acc_code <= CODE_NONE;
               if (scan_res == cand) begin
                  if (db_cnt < CNT_LAST)
                     db_cnt <= db_cnt + 1'b1;
               end else begin
                  cand   <= scan_res;
                  db_cnt <= '0;
               end
            end else begin
               acc_n    <= (tot_n >= 3'd2) ? 2'd2 : tot_n[1:0];
               acc_code <= tot_code;
            end
         end else begin
            slot <= slot + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_NONE;
         stable  <= CODE_NONE;
         code_q  <= CODE_NONE;
         pulse_q <= 1'b0;
      end else begin
         state   <= state_n;
         stable  <= stable_n;
         code_q  <= code_n;
         pulse_q <= pulse_n;
      end
   end

   // A key-to-key change passes through GAP so the consumer always sees a zero before the new digit.
   always_comb begin
      state_n  = state;
      stable_n = stable;
      code_n   = code_q;
      pulse_n  = 1'b0;
      case (state)
         S_NONE: begin
            if (accept && (scan_res != stable)) begin
               stable_n = scan_res;
               code_n   = scan_res;
               if (scan_res < 4'd12) begin
                  state_n = S_KEY;
                  pulse_n = 1'b1;
               end
            end
         end
         S_KEY: begin
            if (accept && (scan_res != stable)) begin
               stable_n = scan_res;
               if (scan_res < 4'd12) begin
                  state_n = S_GAP;
                  code_n  = CODE_NONE;
               end else begin
                  state_n = S_NONE;
                  code_n  = scan_res;
               end
            end
         end
         S_GAP: begin
            state_n = S_KEY;
            code_n  = stable;
            pulse_n = 1'b1;
         end
         default: begin
            state_n = S_NONE;
            code_n  = CODE_NONE;
         end
      endcase
   end

   assign kp.key_row   = row_drv;
   assign kp.key_code  = code_q;
   assign kp.key_pulse = pulse_q;
   assign kp.key_star  = (code_q == 4'd10);
   assign kp.key_hash  = (code_q == 4'd11);
   assign kp.keypad    = (code_q < 4'd10) ? (10'b1 << code_q) : 10'b0;
endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed self-checking bench for keypad_scan
module tb_keypad_scan;
   logic clk;
   logic rst;
   keypad_scan_if kif();

   keypad_scan #(.ROW_CYC(4), .DB_SCANS(3)) dut (
      .clk (clk),
      .rst (rst),
      .kp  (kif)
   );

   int errors = 0;
   int checks = 0;
   int pulse_cnt = 0;
   int excl_bad = 0;

   // pressed bit index = row*3 + col
   logic [11:0] pressed;
   logic [2:0]  model_col;
   logic        col_ovr_en;
   logic [2:0]  col_ovr;

   always_comb begin
      model_col = 3'b111;
      for (int r = 0; r < 4; r++)
         if (kif.key_row[r] == 1'b0)
            for (int c = 0; c < 3; c++)
               if (pressed[r*3 + c]) model_col[c] = 1'b0;
   end
   assign kif.key_col = col_ovr_en ? col_ovr : model_col;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (kif.key_pulse === 1'b1) pulse_cnt++;
      if (rst && (((int'(kif.keypad != 10'd0) + int'(kif.key_star) + int'(kif.key_hash)) > 1) ||
                  ($countones(kif.keypad) > 1)))
         excl_bad++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic align();
      int n;
      n = 0;
      while (kif.key_row == 4'b1110 && n < 20) begin @(negedge clk); n++; end
      while (kif.key_row != 4'b1110 && n < 40) begin @(negedge clk); n++; end
      chk("align", 32'(kif.key_row), 32'h0000000e);
   endtask

   task automatic press_wait(input logic [11:0] keys, input logic [3:0] code, input string tag);
      int n;
      align();
      pressed = keys;
      n = 0;
      while (kif.key_code !== code && n < 67) begin @(negedge clk); n++; end
      chk(tag, 32'(kif.key_code), 32'(code));
   endtask

   initial begin
      int p0, bad;
      logic [3:0] exp_row;
      rst = 1'b0;
      pressed = '0;
      col_ovr_en = 1'b1;
      col_ovr = 3'b111;

      // reset held while columns toggle
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         col_ovr = col_ovr ^ 3'b101;
         chk("rst_row", 32'(kif.key_row), 32'h0000000e);
      end
      chk("rst_keypad", 32'(kif.keypad), 32'h0);
      chk("rst_code", 32'(kif.key_code), 32'hf);
      chk("rst_pulse", 32'(kif.key_pulse), 32'h0);
      chk("rst_star_hash", 32'({kif.key_star, kif.key_hash}), 32'h0);
      col_ovr_en = 1'b0;
      rst = 1'b1;

      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         exp_row = ~(4'b0001 << ((k / 4) % 4));
         chk("row_cycle", 32'(kif.key_row), 32'(exp_row));
      end

      // digit 5 press, hold, release
      #1 p0 = pulse_cnt;
      press_wait(12'b1 << 4, 4'd5, "press5_code");
      chk("press5_keypad", 32'(kif.keypad), 32'b0000100000);
      repeat (200) @(negedge clk);
      #1 chk("press5_one_pulse", 32'(pulse_cnt - p0), 32'd1);
      press_wait(12'b0, 4'd15, "release5_code");
      chk("release5_keypad", 32'(kif.keypad), 32'h0);

      // bouncing 0 contact: P R P R P then held
      align();
      #1 p0 = pulse_cnt;
      bad = 0;
      for (int k = 0; k < 128; k++) begin
         if (k % 16 == 0)
            pressed = ((k / 16) < 5 && ((k / 16) % 2 == 1)) ? 12'b0 : (12'b1 << 10);
         if (kif.keypad != 10'd0) bad++;
         @(negedge clk);
      end
      chk("bounce_quiet", 32'(bad), 32'd0);
      chk("bounce_key0", 32'(kif.keypad), 32'b0000000001);
      chk("bounce_code", 32'(kif.key_code), 32'd0);
      #1 chk("bounce_one_pulse", 32'(pulse_cnt - p0), 32'd1);
      press_wait(12'b0, 4'd15, "release0_code");

      // hash key
      #1 p0 = pulse_cnt;
      press_wait(12'b1 << 11, 4'd11, "hash_code");
      chk("hash_level", 32'({kif.key_star, kif.key_hash}), 32'b01);
      chk("hash_keypad", 32'(kif.keypad), 32'h0);
      @(negedge clk);
      #1 chk("hash_pulse", 32'(pulse_cnt - p0), 32'd1);
      press_wait(12'b0, 4'd15, "release_hash");

      // 1 and 2 together
      #1 p0 = pulse_cnt;
      press_wait(12'b11, 4'd14, "multi_code");
      chk("multi_outputs", 32'({kif.keypad, kif.key_star, kif.key_hash}), 32'h0);
      @(negedge clk);
      #1 chk("multi_no_pulse", 32'(pulse_cnt - p0), 32'd0);
      press_wait(12'b0, 4'd15, "release_multi");

      // roll-over 7 -> 8 without release
      press_wait(12'b1 << 6, 4'd7, "roll7_code");
      chk("roll7_keypad", 32'(kif.keypad), 32'b0010000000);
      align();
      pressed = 12'b1 << 7;
      bad = 0;
      while (kif.keypad === 10'b0010000000 && bad < 67) begin @(negedge clk); bad++; end
      chk("roll_gap_keypad", 32'(kif.keypad), 32'h0);
      chk("roll_gap_code", 32'(kif.key_code), 32'hf);
      chk("roll_gap_pulse", 32'(kif.key_pulse), 32'h0);
      @(negedge clk);
      chk("roll8_keypad", 32'(kif.keypad), 32'b0100000000);
      chk("roll8_pulse", 32'(kif.key_pulse), 32'h1);
      @(negedge clk);
      chk("roll8_pulse_end", 32'(kif.key_pulse), 32'h0);
      press_wait(12'b0, 4'd15, "release8");

      // reset after two matching scans of 3 discards debounce progress
      align();
      pressed = 12'b1 << 2;
      repeat (34) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_row", 32'(kif.key_row), 32'h0000000e);
      chk("midrst_code", 32'(kif.key_code), 32'hf);
      chk("midrst_keypad", 32'(kif.keypad), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      bad = 0;
      for (int k = 0; k < 63; k++) begin
         @(negedge clk);
         if (kif.keypad != 10'd0) bad++;
      end
      chk("midrst_fresh_scans", 32'(bad), 32'd0);
      @(negedge clk);
      chk("midrst_key3", 32'(kif.keypad), 32'b0000001000);
      chk("midrst_pulse", 32'(kif.key_pulse), 32'h1);

      chk("exclusive_outputs", 32'(excl_bad), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
